// File: rtl/cache_plru_tree.sv
// rtl/cache_plru_tree.sv - tree pseudo-LRU replacement engine, one heap-indexed tree per cache set
// Optional registered victim outputs: define CACHE_PLRU_REG_OUT_EN.
module cache_plru_tree #(
    parameter int N_WAYS     = 4,
    parameter int LINE_OFF_W = 0
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      write_en,
    input  logic [N_WAYS-1:0]                         way_hit,
    input  logic [((LINE_OFF_W > 0) ? LINE_OFF_W : 1)-1:0] line_addr,
    output logic [N_WAYS-1:0]                         way_select,
    output logic [$clog2(N_WAYS)-1:0]                 way_select_bin
);

    localparam int LVL   = $clog2(N_WAYS);
    localparam int LA_W  = (LINE_OFF_W > 0) ? LINE_OFF_W : 1;
    localparam int N_ARR = 2 ** LA_W;
    localparam int T_W   = N_WAYS - 1;

    logic [T_W-1:0]          r_tree [N_ARR];

    logic [LA_W-1:0]         w_set;
    logic [T_W-1:0]          w_tree_cur;
    logic [2*N_WAYS-1:0]     w_heap;
    logic [LVL:0]            w_node;
    logic [LVL-1:0]          w_vic_bin;
    logic [N_WAYS-1:0]       w_vic;
    logic [LVL-1:0]          w_hit_idx;
    logic                    w_hit_any;
    logic [LVL:0]            w_leaf;
    logic [T_W-1:0]          w_tree_nxt;

    assign w_set      = (LINE_OFF_W > 0) ? line_addr : '0;
    assign w_tree_cur = r_tree[w_set];

    // Heap view: bit n holds node n, so a node number indexes it directly.
    assign w_heap = {{N_WAYS{1'b0}}, w_tree_cur, 1'b0};

    always_comb begin
        w_node = (LVL + 1)'(1);
        for (int l = 0; l < LVL; l++) begin
            w_node = {w_node[LVL-1:0], w_heap[w_node]};
        end
    end

    assign w_vic_bin = w_node[LVL-1:0];
    assign w_vic     = {{(N_WAYS-1){1'b0}}, 1'b1} << w_vic_bin;

    always_comb begin
        w_hit_idx = '0;
        w_hit_any = 1'b0;
        for (int i = N_WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                w_hit_idx = LVL'(i);
                w_hit_any = 1'b1;
            end
        end
    end

    assign w_leaf = {1'b1, w_hit_idx};

    // A node lies on the hit path when it is an ancestor of the hit leaf;
    // it is then pointed away from the branch the hit way took.
    always_comb begin
        w_tree_nxt = w_tree_cur;
        for (int l = 0; l < LVL; l++) begin
            for (int k = 0; k < (1 << l); k++) begin
                if ((w_leaf >> (LVL - l)) == (LVL + 1)'((1 << l) + k)) begin
                    w_tree_nxt[(1 << l) + k - 1] = ~w_hit_idx[LVL-1-l];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < N_ARR; s++) begin
                r_tree[s] <= '0;
            end
        end else if (write_en && w_hit_any) begin
            r_tree[w_set] <= w_tree_nxt;
        end
    end

`ifdef CACHE_PLRU_REG_OUT_EN
    logic [N_WAYS-1:0] r_sel;
    logic [LVL-1:0]    r_sel_bin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel     <= {{(N_WAYS-1){1'b0}}, 1'b1};
            r_sel_bin <= '0;
        end else begin
            r_sel     <= w_vic;
            r_sel_bin <= w_vic_bin;
        end
    end

    assign way_select     = r_sel;
    assign way_select_bin = r_sel_bin;
`else
    assign way_select     = w_vic;
    assign way_select_bin = w_vic_bin;
`endif

endmodule

// File: tb/tb_cache_plru_tree.sv
// tb/tb_cache_plru_tree.sv - self-checking bench for cache_plru_tree (4-way/2-set and 8-way/4-set)
module tb_cache_plru_tree;

`ifdef CACHE_PLRU_REG_OUT_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       we4, we8;
    logic [3:0] hit4, sel4;
    logic [7:0] hit8, sel8;
    logic [0:0] addr4;
    logic [1:0] addr8, bin4;
    logic [2:0] bin8;

    cache_plru_tree #(.N_WAYS(4), .LINE_OFF_W(1)) dut4 (
        .clk(clk), .reset(rst), .write_en(we4), .way_hit(hit4),
        .line_addr(addr4), .way_select(sel4), .way_select_bin(bin4)
    );

    cache_plru_tree #(.N_WAYS(8), .LINE_OFF_W(2)) dut8 (
        .clk(clk), .reset(rst), .write_en(we8), .way_hit(hit8),
        .line_addr(addr8), .way_select(sel8), .way_select_bin(bin8)
    );

    int n_checks = 0;
    int n_errors = 0;

    int model [2][4][16];
    int prev_v [2];

    logic       tab4_en = 1'b0, tab8_en = 1'b0;
    logic [3:0] tab4_exp = 4'b0001, tab4_prev = 4'b0001;
    logic [7:0] tab8_exp = 8'h01, tab8_prev = 8'h01;

    typedef struct {
        logic       rst;
        logic       we;
        logic [3:0] hit;
        logic       addr;
        logic       chk;
        logic [3:0] exp;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic w, logic [3:0] h, logic a, logic c, logic [3:0] e);
        vec_t v;
        v.rst = r; v.we = w; v.hit = h; v.addr = a; v.chk = c; v.exp = e;
        return v;
    endfunction

    function automatic int nw(int inst);
        return (inst == 0) ? 4 : 8;
    endfunction

    function automatic int victim(int inst, int set);
        int n = 1;
        while (n < nw(inst)) n = 2 * n + model[inst][set][n];
        return n - nw(inst);
    endfunction

    task automatic touch(input int inst, input int set, input int hit);
        int w = -1;
        int n, p;
        for (int i = nw(inst) - 1; i >= 0; i--) if (((hit >> i) & 1) == 1) w = i;
        if (w < 0) return;
        n = w + nw(inst);
        while (n > 1) begin
            p = n / 2;
            model[inst][set][p] = (n == 2 * p) ? 1 : 0;
            n = p;
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 2; a++)
            for (int s = 0; s < 4; s++)
                for (int n = 0; n < 16; n++) model[a][s][n] = 0;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic w4, input logic [3:0] h4, input logic a4,
                        input logic w8, input logic [7:0] h8, input logic [1:0] a8, input bit mchk);
        int e4, e8, x4, x8;
        logic [3:0] te4;
        logic [7:0] te8;
        rst = r; we4 = w4; hit4 = h4; addr4 = a4; we8 = w8; hit8 = h8; addr8 = a8;
        #1;
        e4 = victim(0, int'(a4));
        e8 = victim(1, int'(a8));
        if (mchk) begin
            x4 = REG ? prev_v[0] : e4;
            x8 = REG ? prev_v[1] : e8;
            check("model_sel4", 8'(sel4), 8'(1 << x4));
            check("model_bin4", 8'(bin4), 8'(x4));
            check("model_sel8", sel8, 8'(1 << x8));
            check("model_bin8", 8'(bin8), 8'(x8));
        end
        if (tab4_en) begin
            te4 = REG ? tab4_prev : tab4_exp;
            check("tab_sel4", 8'(sel4), 8'(te4));
            check("tab_bin4", 8'(bin4), 8'($clog2(te4)));
        end
        if (tab8_en) begin
            te8 = REG ? tab8_prev : tab8_exp;
            check("seq_sel8", sel8, te8);
            check("seq_bin8", 8'(bin8), 8'($clog2(te8)));
        end
        @(posedge clk);
        if (r) model_reset();
        else begin
            if (w4) touch(0, int'(a4), int'(h4));
            if (w8) touch(1, int'(a8), int'(h8));
        end
        prev_v[0] = r ? 0 : e4;
        prev_v[1] = r ? 0 : e8;
        tab4_prev = r ? 4'b0001 : tab4_exp;
        tab8_prev = r ? 8'h01 : tab8_exp;
        @(negedge clk);
    endtask

    function automatic logic [7:0] rhit(int ways);
        logic [7:0] mask;
        mask = 8'((1 << ways) - 1);
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'($urandom) & mask;
            default: return 8'(1 << $urandom_range(0, ways - 1));
        endcase
    endfunction

    int seq8 [9] = '{0, 4, 2, 6, 1, 5, 3, 7, 0};

    initial begin
        rst = 1'b1; we4 = 1'b0; we8 = 1'b0; hit4 = '0; hit8 = '0; addr4 = '0; addr8 = '0;
        prev_v[0] = 0; prev_v[1] = 0;
        model_reset();

        for (int i = 0; i < 5; i++) tv.push_back(mk(1, 0, 4'b0000, 0, 0, 4'b0001));
        tv.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b0001));
        tv.push_back(mk(0, 0, 4'b0000, 1, 1, 4'b0001));
        // miss-only walk on set 0
        tv.push_back(mk(0, 1, 4'b0001, 0, 1, 4'b0001));
        tv.push_back(mk(0, 1, 4'b0100, 0, 1, 4'b0100));
        tv.push_back(mk(0, 1, 4'b0010, 0, 1, 4'b0010));
        tv.push_back(mk(0, 1, 4'b1000, 0, 1, 4'b1000));
        tv.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b0001));
        // set isolation on set 1
        tv.push_back(mk(0, 0, 4'b0000, 1, 1, 4'b0001));
        tv.push_back(mk(0, 1, 4'b0100, 1, 1, 4'b0001));
        tv.push_back(mk(0, 1, 4'b0001, 1, 1, 4'b0001));
        tv.push_back(mk(0, 0, 4'b0000, 1, 1, 4'b1000));
        tv.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b0001));
        // null and multi-bit hits
        tv.push_back(mk(0, 1, 4'b0000, 0, 1, 4'b0001));
        tv.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b0001));
        tv.push_back(mk(0, 1, 4'b1010, 0, 1, 4'b0001));
        tv.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b0100));
        // reset dominating a concurrent write
        tv.push_back(mk(1, 0, 4'b0000, 0, 0, 4'b0001));
        tv.push_back(mk(0, 1, 4'b0001, 0, 1, 4'b0001));
        tv.push_back(mk(0, 1, 4'b0100, 0, 1, 4'b0100));
        tv.push_back(mk(0, 1, 4'b0010, 0, 1, 4'b0010));
        tv.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b1000));
        tv.push_back(mk(1, 1, 4'b1000, 0, 0, 4'b0001));
        tv.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b0001));
        tv.push_back(mk(0, 0, 4'b0000, 1, 1, 4'b0001));
        // write set 0 while the address moves to set 1
        tv.push_back(mk(0, 1, 4'b0001, 0, 1, 4'b0001));
        tv.push_back(mk(0, 0, 4'b0000, 1, 1, 4'b0001));
        tv.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b0100));

        @(negedge clk);
        foreach (tv[i]) begin
            tab4_en  = tv[i].chk;
            tab4_exp = tv[i].exp;
            step(tv[i].rst, tv[i].we, tv[i].hit, tv[i].addr, 1'b0, 8'h00, 2'd0, tv[i].chk);
        end
        tab4_en = 1'b0;

        step(1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            tab8_en  = 1'b1;
            tab8_exp = 8'(1 << seq8[k]);
            step(1'b0, 1'b0, 4'b0, 1'b0, (k < 8), 8'(1 << seq8[k]), 2'd2, 1'b1);
        end
        tab8_en = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom), 4'(rhit(4)), 1'($urandom),
                 1'($urandom), rhit(8), 2'($urandom), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_plru_tree.md
# cache_plru_tree

Tree pseudo-LRU replacement engine for the set-associative cache: the responder side of the `write_en`/`way_hit` → `way_select` replacement interface. It keeps one PLRU tree per cache line (set) and updates that set's tree on each hit or fill reported by the cache controller. It also presents the victim way for the addressed set in one-hot and binary form. It sits beside the tag/valid memories in the cache core and is driven by the controller's hit/allocate path.

## Interface
- `N_WAYS`, default 4: associativity; power of 2, ≥2.
- `LINE_OFF_W`, default 0: set-index width; number of sets `N_LINES = 2**LINE_OFF_W`.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `write_en`  in  1  update strobe: commit `way_hit` into the tree of set `line_addr`.
- `way_hit`  in  N_WAYS  one-hot way just accessed (hit or fill).
- `line_addr`  in  max(LINE_OFF_W,1)  set index; only low LINE_OFF_W bits used; ignored when LINE_OFF_W=0.
- `way_select`  out  N_WAYS  one-hot victim way for set `line_addr`.
- `way_select_bin`  out  $clog2(N_WAYS)  binary index of `way_select`.

## Operation
- State: `N_LINES` × `(N_WAYS-1)` tree bits, heap-indexed. Root is node 1; children of node n are 2n and 2n+1; node n is stored in bit n-1. Leaves n = N_WAYS..2·N_WAYS-1 map to way n-N_WAYS.
- Victim walk: start at n=1. Bit=0 → go to 2n (lower ways); bit=1 → go to 2n+1. Stop after log2(N_WAYS) levels. `way_select_bin` = leaf − N_WAYS; `way_select` = 1 << `way_select_bin`.
- Update walk (`write_en`=1): encode `way_hit` to w, using the lowest set bit if it is not one-hot. On every node on w's path:
  - bit ← 1 if w is in the lower subtree;
  - bit ← 0 if w is in the upper subtree (points away from w).
  - Off-path nodes and all other sets are unchanged.
- `write_en`=1 with `way_hit`=0: no state change.
- Reset: all tree bits of all sets cleared → `way_select`=0…01, `way_select_bin`=0. Reset dominates a concurrent `write_en`.
- Miss-only sequence (hit = current select, same set) for N_WAYS=4 selects ways 0,2,1,3,0,… ; the period is N_WAYS.

## Timing
- Update latency: tree bits change at the rising edge on which `write_en`=1. The new victim is visible in the following cycle.
- Read (default): `way_select`/`way_select_bin` are combinational from current state and current `line_addr`.
  - In a write cycle they show the pre-update victim.
  - Write to set A while `line_addr` moves to set B the next cycle: B is unaffected.
- `write_en` has no handshake; one update per asserted cycle. Back-to-back writes to the same set each see the state left by the previous edge.
- Reset mid-sequence: state is fully cleared at that edge; the walk restarts from way 0 on the next cycle.

## Configuration
- `CACHE_PLRU_REG_OUT_EN` defined:
  - `way_select`/`way_select_bin` are registered. At each edge the register loads the combinational victim for `line_addr` computed from pre-edge state.
  - Outputs are therefore valid one cycle after `line_addr`, and reflect a write one cycle later than in default mode (two cycles after the `write_en` cycle).
  - Reset loads 0…01 / 0.
- `CACHE_PLRU_REG_OUT_EN` undefined: outputs are purely combinational as described above; no extra registers.

## Test plan
- Reset: hold `reset` 5 cycles, release → `way_select`=0001, `way_select_bin`=0 for `line_addr`=0 and 1 (N_WAYS=4, LINE_OFF_W=1).
- Miss sequence, N_WAYS=4, set 0: each cycle `way_hit`←`way_select`, pulse `write_en` → selects 0001,0100,0010,1000,0001. For N_WAYS=8 → ways 0,4,2,6,1,5,3,7,0.
- Set isolation: hit way 2 (0100) on set 1 → set 1 select becomes 0001→ way 0 still? no: tree from reset (root=0,node2=0) with w=2 sets root=0,node3=1 → set 1 select 0001; then hit way 0 on set 1 → 1000; set 0 stays 0001 throughout.
- Null/invalid hit: `write_en`=1 with `way_hit`=0000 → select unchanged. `way_hit`=1010 → treated as way 1, so from reset the next select is 0100.
- Reset mid-operation: after three miss updates (select 1000), assert `reset` one cycle together with `write_en` → next select 0001.
- With `CACHE_PLRU_REG_OUT_EN`: repeat the miss sequence. Each new select appears one cycle later than in default mode; change `line_addr` 0→1 and check the output follows after exactly one edge.
